// File: rtl/fir_sequencer.sv
// fir_sequencer: drives a bit-serial symmetric FIR filter.
// - Serially loads the coefficient chain from a parallel-written bank.
// - For each accepted sample: start pulse, wait for done, then a one-entry
//   output register holds the result.
// - A watchdog abandons a sample whose filter never reports done.
module fir_sequencer #(
    parameter int DataWidth     = 12,
    parameter int NTaps         = 8,
    parameter int TimeoutCycles = 64,
    localparam int NCoeffs      = NTaps / 2,
    localparam int AddrW        = (NCoeffs > 1) ? $clog2(NCoeffs) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 coeff_we,
    input  logic [AddrW-1:0]     coeff_addr,
    input  logic [DataWidth-1:0] coeff_wdata,
    input  logic                 cfg_load,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DataWidth-1:0] s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DataWidth-1:0] m_data,
    output logic                 fir_start,
    output logic [DataWidth-1:0] fir_x,
    output logic                 fir_coeff_load,
    output logic                 fir_coeff,
    output logic                 fir_lock,
    input  logic                 fir_done,
    input  logic [DataWidth-1:0] fir_y,
    output logic                 busy,
    output logic                 err_timeout,
    input  logic                 err_clr
);

    localparam int TotalBits = NCoeffs * DataWidth;
    localparam int BitCntW   = (TotalBits > 1) ? $clog2(TotalBits) : 1;
    localparam int WdW       = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_BUSY
    } state_t;

    state_t                 state_q, state_d;
    logic                   load_pending_q, load_pending_d;
    logic [DataWidth-1:0]   bank_q [NCoeffs];
    logic [DataWidth-1:0]   bank_d [NCoeffs];
    logic [TotalBits-1:0]   snap;
    logic [TotalBits-1:0]   shreg_q, shreg_d;
    logic [BitCntW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [WdW-1:0]         wd_cnt_q, wd_cnt_d;
    logic [DataWidth-1:0]   x_q, x_d;
    logic                   m_valid_q, m_valid_d;
    logic [DataWidth-1:0]   m_data_q, m_data_d;
    logic                   err_q, err_d;
    logic                   s_ready_w;

    // Per-entry bank write decode and the parallel snapshot image.
    // Entry NCoeffs-1 lands in the MSBs so it is shifted out first.
    genvar gi;
    generate
        for (gi = 0; gi < NCoeffs; gi++) begin : g_bank
            assign bank_d[gi] = (coeff_we && (coeff_addr == AddrW'(gi))) ? coeff_wdata : bank_q[gi];
            assign snap[gi*DataWidth +: DataWidth] = bank_q[gi];
        end
    endgenerate

    // Accept only in IDLE, with no load queued and room in the output register.
    assign s_ready_w = (state_q == ST_IDLE) && !load_pending_q && (!m_valid_q || m_ready);

    // Coefficient bank registers; cleared by reset along with everything else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCoeffs; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCoeffs; i++) begin
                bank_q[i] <= bank_d[i];
            end
        end
    end

    // Sequencer state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            load_pending_q <= 1'b0;
            shreg_q        <= '0;
            bit_cnt_q      <= '0;
            wd_cnt_q       <= '0;
            x_q            <= '0;
            m_valid_q      <= 1'b0;
            m_data_q       <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            load_pending_q <= load_pending_d;
            shreg_q        <= shreg_d;
            bit_cnt_q      <= bit_cnt_d;
            wd_cnt_q       <= wd_cnt_d;
            x_q            <= x_d;
            m_valid_q      <= m_valid_d;
            m_data_q       <= m_data_d;
            err_q          <= err_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d        = state_q;
        load_pending_d = load_pending_q | cfg_load;
        shreg_d        = shreg_q;
        bit_cnt_d      = bit_cnt_q;
        wd_cnt_d       = wd_cnt_q;
        x_d            = x_q;
        m_valid_d      = m_valid_q;
        m_data_d       = m_data_q;
        err_d          = err_q;

        // Drain first; a capture below can only happen when the register is empty.
        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
        // Clear first so that a timeout in the same cycle overrides it.
        if (err_clr) begin
            err_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (load_pending_q) begin
                    state_d        = ST_LOAD;
                    load_pending_d = 1'b0;
                    shreg_d        = snap;
                    bit_cnt_d      = '0;
                end else if (s_valid && s_ready_w) begin
                    // A cfg_load arriving with the handshake stays queued.
                    x_d     = s_data;
                    state_d = ST_START;
                end else if (cfg_load) begin
                    // Fresh request while idle: start shifting right away.
                    state_d        = ST_LOAD;
                    load_pending_d = 1'b0;
                    shreg_d        = snap;
                    bit_cnt_d      = '0;
                end
            end
            ST_LOAD: begin
                shreg_d   = {shreg_q[TotalBits-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BitCntW'(TotalBits - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                wd_cnt_d = '0;
                state_d  = ST_BUSY;
            end
            ST_BUSY: begin
                if (fir_done) begin
                    m_data_d  = fir_y;
                    m_valid_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (wd_cnt_q == WdW'(TimeoutCycles - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign s_ready        = s_ready_w;
    assign m_valid        = m_valid_q;
    assign m_data         = m_data_q;
    assign fir_start      = (state_q == ST_START);
    assign fir_x          = x_q;
    assign fir_coeff_load = (state_q == ST_LOAD);
    assign fir_coeff      = (state_q == ST_LOAD) && shreg_q[TotalBits-1];
    // Unlocked chain: the coefficients rotate back to home order every sample.
    assign fir_lock       = 1'b0;
    assign busy           = (state_q != ST_IDLE);
    assign err_timeout    = err_q;

endmodule

// File: tb/tb_fir_sequencer.sv
// Bench for fir_sequencer with a behavioural filter stub.
// The stub returns y = x ^ KEY a programmable number of cycles after start.
module tb_fir_sequencer;

    localparam int DW = 12;
    localparam int NT = 8;
    localparam int NC = NT / 2;
    localparam int TO = 64;
    localparam int TB = NC * DW;
    localparam logic [DW-1:0] KEY = 12'h5A3;

    logic          clk;
    logic          rst;
    logic          coeff_we;
    logic [1:0]    coeff_addr;
    logic [DW-1:0] coeff_wdata;
    logic          cfg_load;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          fir_start;
    logic [DW-1:0] fir_x;
    logic          fir_coeff_load;
    logic          fir_coeff;
    logic          fir_lock;
    logic          fir_done;
    logic [DW-1:0] fir_y;
    logic          busy;
    logic          err_timeout;
    logic          err_clr;

    fir_sequencer #(.DataWidth(DW), .NTaps(NT), .TimeoutCycles(TO)) dut (
        .clk(clk), .rst(rst),
        .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_wdata(coeff_wdata),
        .cfg_load(cfg_load),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .fir_start(fir_start), .fir_x(fir_x),
        .fir_coeff_load(fir_coeff_load), .fir_coeff(fir_coeff), .fir_lock(fir_lock),
        .fir_done(fir_done), .fir_y(fir_y),
        .busy(busy), .err_timeout(err_timeout), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Filter stub: counts down from stub_lat after seeing fir_start.
    logic [6:0]    stub_lat   = 7'd49;
    logic          stub_hang  = 1'b0;
    logic          force_done = 1'b0;
    logic [6:0]    cd         = 7'd0;
    logic [DW-1:0] stub_x     = '0;

    always @(posedge clk) begin
        if (fir_start && !stub_hang) begin
            cd     <= stub_lat;
            stub_x <= fir_x;
        end else if (cd != 7'd0) begin
            cd <= cd - 7'd1;
        end
    end
    assign fir_done = (cd == 7'd1) || force_done;
    assign fir_y    = (cd == 7'd1) ? (stub_x ^ KEY) : 12'hFFF;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] mbank    [NC];
    logic [DW-1:0] exp_bank [NC];
    logic          stream   [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input logic [DW-1:0] val);
        coeff_we    = 1'b1;
        coeff_addr  = addr[1:0];
        coeff_wdata = val;
        tick();
        coeff_we    = 1'b0;
        mbank[addr] = val;
        $display("write bank[%0d] = 0x%03h", addr, val);
    endtask

    // Called in the first LOAD cycle; records the serial stream.
    task automatic collect_load();
        int n;
        int srdy_hi;
        n = 0;
        srdy_hi = 0;
        stream.delete();
        while (fir_coeff_load === 1'b1 && n < TB + 20) begin
            stream.push_back(fir_coeff);
            if (s_ready !== 1'b0) srdy_hi++;
            tick();
            n++;
        end
        chk("load_len", n, TB);
        chk("load_s_ready_low", srdy_hi, 0);
    endtask

    // Filter coefficient k is the (NC-1-k)th word of the MSB-first stream.
    task automatic check_coeffs();
        logic [DW-1:0] w;
        for (int j = 0; j < NC; j++) begin
            w = '0;
            for (int b = 0; b < DW; b++) begin
                w = {w[DW-2:0], stream[j*DW + b]};
            end
            chk($sformatf("coeff[%0d]", NC - 1 - j), w, exp_bank[NC - 1 - j]);
        end
        $display("load done: coeffs checked, %0d bits", stream.size());
    endtask

    task automatic do_load();
        for (int i = 0; i < NC; i++) exp_bank[i] = mbank[i];
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        chk("load_first_cycle", fir_coeff_load, 1);
        collect_load();
        check_coeffs();
    endtask

    // Returns in the first BUSY cycle (two cycles after the handshake edge).
    task automatic send(input logic [DW-1:0] x);
        int k;
        s_valid = 1'b1;
        s_data  = x;
        k = 0;
        while (s_ready !== 1'b1 && k < 300) begin
            tick();
            k++;
        end
        chk("accept_wait", s_ready, 1);
        tick();
        s_valid = 1'b0;
        s_data  = DW'($urandom);
        chk("start_pulse", fir_start, 1);
        chk("start_x", fir_x, x);
        tick();
        chk("start_single", fir_start, 0);
        chk("busy_after_start", busy, 1);
        chk("x_held", fir_x, x);
        $display("sample 0x%03h accepted", x);
    endtask

    task automatic wait_result(input logic [DW-1:0] x, input int lat);
        int k;
        k = 0;
        while (m_valid !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        chk("result_latency", k, lat);
        chk("result_data", m_data, x ^ KEY);
        $display("result for 0x%03h: m_data=0x%03h after %0d cycles", x, m_data, k);
    endtask

    initial begin
        logic [DW-1:0] a, b, c, d, x;
        int k, lat, stall;

        rst = 1'b1; coeff_we = 1'b0; coeff_addr = '0; coeff_wdata = '0;
        cfg_load = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1; err_clr = 1'b0;
        for (int i = 0; i < NC; i++) mbank[i] = '0;
        tick();
        tick();
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_fir_start", fir_start, 0);
        chk("rst_fir_x", fir_x, 0);
        chk("rst_coeff_load", fir_coeff_load, 0);
        chk("rst_coeff", fir_coeff, 0);
        chk("rst_lock", fir_lock, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_timeout, 0);
        rst = 1'b0;
        tick();
        $display("reset checked");

        // Directed coefficient load.
        wr(0, 12'h7FF); wr(1, 12'h400); wr(2, 12'h001); wr(3, 12'h800);
        do_load();

        // Write and load on the same edge: snapshot must take the old value.
        for (int i = 0; i < NC; i++) exp_bank[i] = mbank[i];
        coeff_we = 1'b1; coeff_addr = 2'd0; coeff_wdata = 12'h2A5; cfg_load = 1'b1;
        tick();
        coeff_we = 1'b0; cfg_load = 1'b0;
        mbank[0] = 12'h2A5;
        chk("wl_first_cycle", fir_coeff_load, 1);
        collect_load();
        check_coeffs();
        do_load();

        // Randomised bank contents.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NC; i++) wr(i, DW'($urandom));
            do_load();
        end

        // Single sample through the reference-latency stub.
        stub_lat = 7'd49;
        a = 12'h123;
        send(a);
        wait_result(a, 49);
        tick();
        chk("m_valid_one_cycle", m_valid, 0);

        // Back-pressure: output held, second sample blocked until drain.
        m_ready = 1'b0;
        a = DW'($urandom);
        b = DW'($urandom);
        send(a);
        wait_result(a, 49);
        s_valid = 1'b1;
        s_data  = b;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_s_ready", s_ready, 0);
            chk("bp_m_valid", m_valid, 1);
            chk("bp_m_data", m_data, a ^ KEY);
        end
        m_ready = 1'b1;
        #1;
        chk("bp_ready_on_drain", s_ready, 1);
        tick();
        s_valid = 1'b0;
        chk("bp_drained", m_valid, 0);
        chk("bp_start", fir_start, 1);
        chk("bp_x", fir_x, b);
        tick();
        wait_result(b, 49);
        $display("back-pressure sequence done");

        // cfg_load during BUSY with a sample waiting.
        for (int i = 0; i < NC; i++) wr(i, DW'($urandom));
        c = DW'($urandom);
        d = DW'($urandom);
        send(c);
        repeat (5) tick();
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        k = 0;
        while (m_valid !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        chk("defer_latency", k, 49 - 6);
        chk("defer_data", m_data, c ^ KEY);
        chk("defer_s_ready", s_ready, 0);
        chk("defer_not_loading_yet", fir_coeff_load, 0);
        for (int i = 0; i < NC; i++) exp_bank[i] = mbank[i];
        tick();
        chk("defer_load_start", fir_coeff_load, 1);
        collect_load();
        check_coeffs();
        chk("defer_ready_after_load", s_ready, 1);
        tick();
        s_valid = 1'b0;
        chk("defer_start", fir_start, 1);
        chk("defer_x", fir_x, d);
        tick();
        wait_result(d, 49);

        // fir_done outside BUSY must be ignored.
        tick();
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        tick();
        chk("stray_done_m_valid", m_valid, 0);
        chk("stray_done_busy", busy, 0);

        // Watchdog: stub never completes.
        stub_hang = 1'b1;
        send(DW'($urandom));
        k = 0;
        while (err_timeout !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        chk("timeout_cycles", k, TO);
        chk("timeout_idle", busy, 0);
        chk("timeout_no_output", m_valid, 0);
        chk("timeout_s_ready", s_ready, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr", err_timeout, 0);
        $display("timeout detected and cleared");

        // err_clr coinciding with the timeout event: set wins.
        send(DW'($urandom));
        repeat (TO - 1) tick();
        chk("pre_timeout_err", err_timeout, 0);
        chk("pre_timeout_busy", busy, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("timeout_set_wins", err_timeout, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr_again", err_timeout, 0);
        stub_hang = 1'b0;

        // Reset 20 cycles into a load.
        for (int i = 0; i < NC; i++) wr(i, DW'($urandom) | 12'h001);
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        repeat (20) tick();
        chk("mid_load_active", fir_coeff_load, 1);
        rst = 1'b1;
        #1;
        chk("rst_load_drop", fir_coeff_load, 0);
        chk("rst_coeff_drop", fir_coeff, 0);
        chk("rst_busy_drop", busy, 0);
        chk("rst_m_data_clr", m_data, 0);
        chk("rst_fir_x_clr", fir_x, 0);
        chk("rst_s_ready_hi", s_ready, 1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < NC; i++) mbank[i] = '0;
        tick();
        do_load();
        for (int i = 0; i < NC; i++) wr(i, DW'($urandom));
        do_load();
        $display("reset during load checked");

        // Random samples with random filter latency and output stalls.
        for (int r = 0; r < 8; r++) begin
            x     = DW'($urandom);
            lat   = $urandom_range(2, 49);
            stall = $urandom_range(0, 3);
            stub_lat = 7'(lat);
            m_ready  = (stall == 0);
            send(x);
            wait_result(x, lat);
            for (int i = 0; i < stall; i++) begin
                tick();
                chk("stall_hold", m_valid, 1);
            end
            m_ready = 1'b1;
            tick();
            chk("stall_drain", m_valid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: observed=expired expected=finish");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/fir_sequencer.md
# fir_sequencer

Controller that sequences the bit-serial symmetric FIR filter block. It programs the filter's coefficient shift chain from a parallel-written coefficient bank and feeds input samples in through a valid/ready handshake. For each sample it issues the one-cycle start pulse, waits for the done pulse, then returns the result through a one-entry output register. A watchdog guards against a filter that never completes.

## Interface
Parameters:
- DataWidth, 12, sample and coefficient width (coefficients SFix<1,DataWidth-1>)
- NTaps, 8, filter taps; even; NCoeffs = NTaps/2
- TimeoutCycles, 64, maximum cycles to wait for fir_done; must be > NCoeffs*DataWidth+1

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous and active-high
- coeff_we  in  1  coefficient bank write strobe
- coeff_addr  in  $clog2(NCoeffs)  bank index
- coeff_wdata  in  DataWidth  coefficient value
- cfg_load  in  1  pulse: shift the bank into the filter
- s_valid / s_ready  in / out  1  input sample handshake
- s_data  in  DataWidth  input sample, unsigned
- m_valid / m_ready  out / in  1  output sample handshake
- m_data  out  DataWidth  filtered sample
- fir_start  out  1  to filter start
- fir_x  out  DataWidth  to filter x
- fir_coeff_load  out  1  to filter coeff_load_in
- fir_coeff  out  1  to filter coeff_in
- fir_lock  out  1  to filter lock; constant 0, so coefficients rotate NCoeffs times per sample and return to home order
- fir_done  in  1  from filter done
- fir_y  in  DataWidth  from filter y
- busy  out  1  high in every state except IDLE
- err_timeout  out  1  sticky watchdog flag
- err_clr  in  1  clears err_timeout

## Operation
- Coefficient bank: NCoeffs x DataWidth registers.
  - Writable in any cycle.
  - A write and a LOAD snapshot on the same edge: the snapshot takes the old value.
- load_pending flag:
  - Set by cfg_load in any state.
  - Cleared on entry to LOAD.
- States:
  - IDLE
  - LOAD: shift out NCoeffs*DataWidth bits
  - START: fir_start=1 for one cycle
  - BUSY: wait for fir_done
- Transitions from IDLE, in priority order:
  - load_pending -> LOAD.
  - Otherwise, on an s_valid&&s_ready handshake -> START.
- IDLE output: s_ready = (state==IDLE) && !load_pending && (!m_valid || m_ready).
- LOAD entry:
  - The bank is snapshotted into an NCoeffs*DataWidth shift register.
  - Shift order: coeff[NCoeffs-1] MSB first, down to coeff[0] LSB last. After the load, filter coefficient k equals bank k.
- LOAD operation: fir_coeff_load=1 and fir_coeff = current bit, for exactly NCoeffs*DataWidth consecutive cycles, then -> IDLE.
- START: fir_x holds the accepted sample, registered at handshake and stable until the next handshake; -> BUSY.
- BUSY:
  - Watchdog counter counts up from 0.
  - On fir_done: capture fir_y into m_data, set m_valid, -> IDLE.
  - If the counter reaches TimeoutCycles-1 without fir_done: set err_timeout, -> IDLE, no output produced.
- Output register: m_valid clears on m_valid&&m_ready. A capture and a drain on the same edge cannot occur, because s_ready guarantees space.
- err_clr: clears err_timeout. If it coincides with a timeout event, the set wins.
- fir_done outside BUSY is ignored.

## Timing
- Reset values:
  - state IDLE, load_pending 0, bank all 0.
  - s_ready 1, m_valid 0, m_data 0.
  - fir_start 0, fir_x 0, fir_coeff_load 0, fir_coeff 0, fir_lock 0.
  - busy 0, err_timeout 0.
- Reset mid-operation:
  - Immediate return to reset values; the bank is also cleared.
  - A partial coefficient load is abandoned; software must reissue cfg_load.
- All outputs are registered or decoded from state; no combinational path from s_valid to s_ready.
- Handshake at edge T:
  - fir_start high during cycle T+1.
  - BUSY from T+2.
  - fir_done at cycle D is captured at edge D; m_valid is high from D+1.
- With the reference filter, fir_done arrives NCoeffs*DataWidth+1 cycles after fir_start (49 for defaults).
  - Handshake to m_valid: about 51 cycles.
  - Back-to-back throughput: one sample per about 51 cycles when m_ready=1.
- cfg_load at edge T in IDLE: fir_coeff_load high for cycles T+1 .. T+NCoeffs*DataWidth; s_ready low during those cycles.
- cfg_load during BUSY: deferred; LOAD starts the cycle after the return to IDLE, before any new sample is accepted.

## Test plan
- Write bank {0x7FF, 0x400, 0x001, 0x800}, pulse cfg_load -> exactly 48 fir_coeff_load cycles. The serial stream is 0x800 MSB-first, then 0x001, 0x400, 0x7FF. Filter model coeffs[k] equal bank k.
- Send a sample through a filter stub that returns done with y=0x123 49 cycles after start -> fir_start is a single cycle one cycle after the handshake; m_data=0x123 with m_valid the cycle after done.
- Hold m_ready=0 after the first result and offer a second sample -> s_ready stays 0 and m_data is held. Raise m_ready -> drain, then the second sample is accepted.
- Pulse cfg_load mid-BUSY while s_valid=1 -> the result completes, LOAD runs next, then the sample is accepted.
- Stub never asserts done -> after 64 BUSY cycles err_timeout=1, m_valid stays 0, and the state is IDLE. err_clr -> err_timeout=0.
- Assert rst 20 cycles into LOAD -> fir_coeff_load drops immediately and all outputs and the bank reach reset values. A fresh load then completes normally.
